// File: rtl/daq_page_ring.sv
// Page ring manager for the DAQ event buffer. It tracks the page being written,
// the oldest completed page, occupancy, almost-full/full status, rejected events
// and a high-water mark. The buffer is divided into 1, 2 or 4 base-page units
// per page depending on the mode latched at clear.
module daq_page_ring #(
  parameter int LOG2_MAX_PAGES  = 6,
  parameter int LOG2_BASE_WORDS = 9,
  parameter int DROP_W          = 16
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic                          clear,
  input  logic [1:0]                    page_size,
  input  logic [LOG2_MAX_PAGES:0]       afull_thresh,
  input  logic                          wr_eoe,
  input  logic [LOG2_BASE_WORDS+1:0]    wr_ptr,
  output logic [LOG2_MAX_PAGES+LOG2_BASE_WORDS-1:0] wr_addr,
  output logic [LOG2_MAX_PAGES-1:0]     wr_buf_id,
  input  logic                          rd_release,
  input  logic [3:0]                    rd_count,
  output logic [LOG2_MAX_PAGES-1:0]     rd_buf_id,
  output logic [LOG2_MAX_PAGES:0]       occupancy,
  output logic                          empty,
  output logic                          full,
  output logic                          almost_full,
  output logic                          wr_drop,
  output logic [DROP_W-1:0]             drop_count,
  output logic [LOG2_MAX_PAGES:0]       hwm,
  output logic [1:0]                    mode
);

  localparam int L  = LOG2_MAX_PAGES;
  localparam int B  = LOG2_BASE_WORDS;
  localparam int A  = L + B;
  localparam int CW = L + 5;

  typedef enum logic [1:0] {
    PM_BASE   = 2'd0,
    PM_DOUBLE = 2'd1,
    PM_QUAD   = 2'd2
  } page_mode_e;

  page_mode_e       mode_q;
  page_mode_e       mode_load;
  logic [L-1:0]     np_mask;
  logic [L:0]       cap;
  logic [3:0]       rel_req;
  logic [CW-1:0]    req_ext;
  logic [CW-1:0]    occ_ext;
  logic [L:0]       rel_n;
  logic             accept;
  logic [L:0]       occ_next;
  logic [A-1:0]     addr_next;

  assign mode = mode_q;

  // Page-index mask and capacity for the active mode; capacity excludes the page in progress.
  always_comb begin
    np_mask = '1;
    case (mode_q)
      PM_BASE:   np_mask = '1;
      PM_DOUBLE: np_mask = {1'b0, {(L-1){1'b1}}};
      default:   np_mask = {2'b00, {(L-2){1'b1}}};
    endcase
    cap = {1'b0, np_mask};
  end

  // Release count (0 means 1), clipped to what is actually held; accept checks room after release.
  always_comb begin
    rel_req   = (rd_count == 4'd0) ? 4'd1 : rd_count;
    req_ext   = CW'(rel_req);
    occ_ext   = CW'(occupancy);
    rel_n     = '0;
    if (rd_release && !clear && !empty)
      rel_n = (req_ext < occ_ext) ? req_ext[L:0] : occupancy;
    accept    = wr_eoe && !clear && ((occupancy - rel_n) < cap);
    occ_next  = occupancy + (L+1)'(accept) - rel_n;
    mode_load = (page_size == 2'd3) ? PM_QUAD : page_mode_e'(page_size);
  end

  // Buffer address: larger pages trade page-index bits for word-pointer bits.
  always_comb begin
    case (mode_q)
      PM_BASE:   addr_next = {wr_buf_id,        wr_ptr[B-1:0]};
      PM_DOUBLE: addr_next = {wr_buf_id[L-2:0], wr_ptr[B:0]};
      default:   addr_next = {wr_buf_id[L-3:0], wr_ptr[B+1:0]};
    endcase
  end

  // Ring pointers, occupancy, drop accounting, high-water mark and mode register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mode_q     <= PM_BASE;
      wr_buf_id  <= '0;
      rd_buf_id  <= '0;
      occupancy  <= '0;
      hwm        <= '0;
      drop_count <= '0;
      wr_drop    <= 1'b0;
      wr_addr    <= '0;
    end else if (clear) begin
      mode_q     <= mode_load;
      wr_buf_id  <= '0;
      rd_buf_id  <= '0;
      occupancy  <= '0;
      hwm        <= '0;
      drop_count <= '0;
      wr_drop    <= 1'b0;
      wr_addr    <= '0;
    end else begin
      wr_buf_id <= (wr_buf_id + L'(accept)) & np_mask;
      rd_buf_id <= (rd_buf_id + rel_n[L-1:0]) & np_mask;
      occupancy <= occ_next;
      hwm       <= (occ_next > hwm) ? occ_next : hwm;
      wr_drop   <= wr_eoe && !accept;
      if (wr_eoe && !accept && (drop_count != '1))
        drop_count <= drop_count + 1'b1;
      wr_addr   <= addr_next;
    end
  end

  // Status flags straight from the occupancy register.
  always_comb begin
    empty       = (occupancy == '0);
    full        = (occupancy == cap);
    almost_full = (afull_thresh != '0) && (occupancy >= afull_thresh);
  end

  // The distance between write and read page always equals the completed-page count.
  ring_invariant: assert property (@(posedge clk) disable iff (!reset_n)
    ((((wr_buf_id - rd_buf_id) & np_mask) == occupancy[L-1:0]) && !occupancy[L]));

endmodule

// File: tb/tb_daq_page_ring.sv
// Bench for daq_page_ring: directed scenarios plus random traffic, checked
// against a queue-of-pages reference model.
module tb_daq_page_ring;

  localparam int L    = 6;
  localparam int B    = 9;
  localparam int DW   = 16;
  localparam int A    = L + B;
  localparam int DMAX = (1 << DW) - 1;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          clear = 1'b0;
  logic [1:0]    page_size = '0;
  logic [L:0]    afull_thresh = '0;
  logic          wr_eoe = 1'b0;
  logic [B+1:0]  wr_ptr = '0;
  logic [A-1:0]  wr_addr;
  logic [L-1:0]  wr_buf_id;
  logic          rd_release = 1'b0;
  logic [3:0]    rd_count = '0;
  logic [L-1:0]  rd_buf_id;
  logic [L:0]    occupancy;
  logic          empty, full, almost_full, wr_drop;
  logic [DW-1:0] drop_count;
  logic [L:0]    hwm;
  logic [1:0]    mode;

  daq_page_ring #(
    .LOG2_MAX_PAGES (L),
    .LOG2_BASE_WORDS(B),
    .DROP_W         (DW)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .clear       (clear),
    .page_size   (page_size),
    .afull_thresh(afull_thresh),
    .wr_eoe      (wr_eoe),
    .wr_ptr      (wr_ptr),
    .wr_addr     (wr_addr),
    .wr_buf_id   (wr_buf_id),
    .rd_release  (rd_release),
    .rd_count    (rd_count),
    .rd_buf_id   (rd_buf_id),
    .occupancy   (occupancy),
    .empty       (empty),
    .full        (full),
    .almost_full (almost_full),
    .wr_drop     (wr_drop),
    .drop_count  (drop_count),
    .hwm         (hwm),
    .mode        (mode)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Reference model: completed pages are held as a queue of page ids.
  int q[$];
  int m_wid   = 0;
  int m_mode  = 0;
  int m_hwm   = 0;
  int m_drops = 0;
  int m_addr  = 0;
  int m_drop  = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset(input int new_mode);
    q.delete();
    m_wid = 0; m_hwm = 0; m_drops = 0; m_addr = 0; m_drop = 0;
    m_mode = new_mode;
  endtask

  task automatic check_all();
    int np, cap, occ, thr;
    np  = 1 << (L - m_mode);
    cap = np - 1;
    occ = q.size();
    thr = int'(afull_thresh);
    check("occupancy",   32'(occupancy),  32'(occ));
    check("wr_buf_id",   32'(wr_buf_id),  32'(m_wid));
    check("rd_buf_id",   32'(rd_buf_id),  32'((occ > 0) ? q[0] : m_wid));
    check("hwm",         32'(hwm),        32'(m_hwm));
    check("drop_count",  32'(drop_count), 32'(m_drops));
    check("wr_drop",     32'(wr_drop),    32'(m_drop));
    check("wr_addr",     32'(wr_addr),    32'(m_addr));
    check("mode",        32'(mode),       32'(m_mode));
    check("empty",       32'(empty),      32'(occ == 0));
    check("full",        32'(full),       32'(occ == cap));
    check("almost_full", 32'(almost_full), 32'((thr != 0) && (occ >= thr)));
  endtask

  // One clock: drive inputs, advance the model with the same inputs, compare after the edge.
  task automatic step(input bit eoe, input bit rel, input int cnt, input int ptr,
                      input bit clr, input int ps);
    int np, cap, occ, r;
    bit acc;
    wr_eoe     = eoe;
    rd_release = rel;
    rd_count   = 4'(cnt);
    wr_ptr     = (B+2)'(ptr);
    clear      = clr;
    page_size  = 2'(ps);
    if (clr) begin
      model_reset((ps == 3) ? 2 : ps);
    end else begin
      np  = 1 << (L - m_mode);
      cap = np - 1;
      occ = q.size();
      r   = 0;
      if (rel) begin
        r = (cnt == 0) ? 1 : cnt;
        if (r > occ) r = occ;
      end
      m_addr = (m_wid << (B + m_mode)) | (ptr & ((1 << (B + m_mode)) - 1));
      acc = eoe && ((occ - r) < cap);
      repeat (r) void'(q.pop_front());
      if (acc) begin
        q.push_back(m_wid);
        m_wid = (m_wid + 1) % np;
      end
      m_drop = (eoe && !acc) ? 1 : 0;
      if (m_drop != 0 && m_drops < DMAX) m_drops++;
      if (q.size() > m_hwm) m_hwm = q.size();
    end
    @(posedge clk);
    #1;
    check_all();
  endtask

  function automatic int rptr();
    return int'($urandom_range(0, (1 << (B + 2)) - 1));
  endfunction

  initial begin
    // Reset state, sampled while reset is held.
    #3;
    model_reset(0);
    check_all();
    #9 reset_n = 1'b1;

    // Fill mode 0 to capacity from the first edge after reset.
    for (int i = 0; i < 63; i++) step(1, 0, 0, rptr(), 0, $urandom_range(0, 3));
    check("fill_occ",  32'(occupancy), 32'd63);
    check("fill_full", 32'(full),      32'd1);
    check("fill_wid",  32'(wr_buf_id), 32'd63);
    step(1, 0, 0, rptr(), 0, 0);
    check("ovf_drop",  32'(wr_drop),    32'd1);
    check("ovf_cnt",   32'(drop_count), 32'd1);
    check("ovf_wid",   32'(wr_buf_id),  32'd63);

    // Write and release together while full.
    step(1, 1, 1, rptr(), 0, 0);
    check("simul_occ", 32'(occupancy), 32'd63);
    check("simul_wid", 32'(wr_buf_id), 32'd0);
    check("simul_rid", 32'(rd_buf_id), 32'd1);

    // Almost-full threshold crossing both ways, high-water mark retained.
    afull_thresh = 7'd10;
    step(0, 0, 0, 0, 1, 0);
    for (int i = 1; i <= 12; i++) begin
      step(1, 0, 0, rptr(), 0, 0);
      if (i == 9)  check("af_below_rise", 32'(almost_full), 32'd0);
      if (i == 10) check("af_rise",       32'(almost_full), 32'd1);
    end
    for (int k = 1; k <= 12; k++) begin
      step(0, 1, 1, rptr(), 0, 0);
      if (k == 2) check("af_at10", 32'(almost_full), 32'd1);
      if (k == 3) check("af_fall", 32'(almost_full), 32'd0);
    end
    check("hwm_held", 32'(hwm), 32'd12);

    // Mode 2: short ring, bundled release larger than occupancy.
    step(0, 0, 0, 0, 1, 2);
    for (int i = 0; i < 5; i++) begin
      step(1, 0, 0, rptr(), 0, 1);
      check("m2_wid_hi", 32'(wr_buf_id[5:4]), 32'd0);
    end
    step(0, 1, 8, rptr(), 0, 0);
    check("m2_occ",    32'(occupancy), 32'd0);
    check("m2_rid",    32'(rd_buf_id), 32'd5);
    check("m2_rid_hi", 32'(rd_buf_id[5:4]), 32'd0);
    step(0, 1, 3, rptr(), 0, 0);

    // Mode 1 address composition.
    step(0, 0, 0, 0, 1, 1);
    for (int i = 0; i < 3; i++) step(1, 0, 0, rptr(), 0, 0);
    step(0, 0, 0, 'h155, 0, 0);
    check("m1_addr", 32'(wr_addr), (32'd3 << 10) | 32'h155);

    // Clear with activity present: 3 maps to mode 2, no drop.
    step(1, 1, 3, rptr(), 1, 3);
    check("clr_mode", 32'(mode),    32'd2);
    check("clr_drop", 32'(wr_drop), 32'd0);

    // Random traffic with occasional clears.
    for (int n = 0; n < 1500; n++) begin
      if ($urandom_range(0, 99) < 2) afull_thresh = 7'($urandom_range(0, 64));
      step($urandom_range(0, 99) < 65, $urandom_range(0, 99) < 35,
           $urandom_range(0, 15), rptr(), $urandom_range(0, 199) < 3,
           $urandom_range(0, 3));
    end

    // Asynchronous reset mid-burst with pages and drops outstanding.
    afull_thresh = '0;
    step(0, 0, 0, 0, 1, 0);
    for (int i = 0; i < 66; i++) step(1, 0, 0, rptr(), 0, 0);
    step(0, 1, 15, rptr(), 0, 0);
    step(0, 1, 15, rptr(), 0, 0);
    step(0, 1, 13, rptr(), 0, 0);
    check("pre_rst_occ",  32'(occupancy),  32'd20);
    check("pre_rst_drop", 32'(drop_count), 32'd3);
    wr_eoe = 1'b1;
    #2 reset_n = 1'b0;
    #1;
    check("rst_occ",  32'(occupancy),  32'd0);
    check("rst_wid",  32'(wr_buf_id),  32'd0);
    check("rst_rid",  32'(rd_buf_id),  32'd0);
    check("rst_hwm",  32'(hwm),        32'd0);
    check("rst_dcnt", 32'(drop_count), 32'd0);
    check("rst_addr", 32'(wr_addr),    32'd0);
    check("rst_mode", 32'(mode),       32'd0);
    check("rst_drop", 32'(wr_drop),    32'd0);
    check("rst_empty", 32'(empty),     32'd1);
    model_reset(0);
    @(negedge clk);
    reset_n = 1'b1;
    step(1, 0, 0, rptr(), 0, 0);
    step(1, 1, 0, rptr(), 0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/daq_page_ring.md
DAQ_PAGE_RING -- requirements
Module: daq_page_ring

Interface
REQ-001 The block SHALL have parameter LOG2_MAX_PAGES, default 6, giving log2 of the page count in mode 0.
REQ-002 The block SHALL have parameter LOG2_BASE_WORDS, default 9, giving log2 of the words per page in mode 0.
REQ-003 The block SHALL have parameter DROP_W, default 16, giving the width of the drop counter.
REQ-004 The block SHALL use L=LOG2_MAX_PAGES and A=L+LOG2_BASE_WORDS as width shorthands throughout.
REQ-005 The block SHALL have port clk, input, width 1: the single clock; all logic is on its rising edge.
REQ-006 The block SHALL have port reset_n, input, width 1: asynchronous, active-low reset.
REQ-007 The block SHALL have port clear, input, width 1: synchronous clear of all pointers and counters, and the mode-load strobe.
REQ-008 The block SHALL have port page_size, input, width 2: page mode; 0 gives 2^L pages of 2^LOG2_BASE_WORDS words, 1 gives half the pages at double the words, 2 or 3 gives a quarter of the pages at four times the words.
REQ-009 The block SHALL have port afull_thresh, input, width L+1: the almost-full occupancy threshold.
REQ-010 The block SHALL have port wr_eoe, input, width 1: one-cycle end-of-event pulse from the write manager.
REQ-011 The block SHALL have port wr_ptr, input, width LOG2_BASE_WORDS+2: word pointer within the page currently being written.
REQ-012 The block SHALL have port wr_addr, output, width A: registered buffer write address.
REQ-013 The block SHALL have port wr_buf_id, output, width L: page currently being written.
REQ-014 The block SHALL have port rd_release, input, width 1: one-cycle pulse releasing completed pages.
REQ-015 The block SHALL have port rd_count, input, width 4: number of pages to release on rd_release (bundle release); 0 is treated as 1.
REQ-016 The block SHALL have port rd_buf_id, output, width L: oldest completed page.
REQ-017 The block SHALL have port occupancy, output, width L+1: number of completed pages not yet released.
REQ-018 The block SHALL have ports empty, full, almost_full, each output, width 1: status flags.
REQ-019 The block SHALL have port wr_drop, output, width 1: one-cycle pulse on each rejected wr_eoe.
REQ-020 The block SHALL have port drop_count, output, width DROP_W: saturating count of rejected events.
REQ-021 The block SHALL have port hwm, output, width L+1: high-water mark of occupancy.
REQ-022 The block SHALL have port mode, output, width 2: currently active page mode.

Function
REQ-023 The block SHALL compute NP (page count) as 2^L, 2^(L-1) and 2^(L-2) for modes 0, 1 and 2 respectively.
REQ-024 The block SHALL hold the most significant buf_id bits that are unused in the active mode at 0.
REQ-025 The block SHALL set capacity CAP=NP-1 completed pages, since the in-progress page is never counted.
REQ-026 The block SHALL load the mode register from page_size (3 maps to 2) only on clear, and SHALL ignore page_size changes at all other times.
REQ-027 The block SHALL compute full, combinationally from registers, as occupancy==CAP.
REQ-028 The block SHALL compute empty as occupancy==0.
REQ-029 The block SHALL compute almost_full as occupancy>=afull_thresh, and SHALL force it to 0 when afull_thresh==0.
REQ-030 On wr_eoe, the block SHALL accept the event if occupancy-R<CAP, where R is the number of pages released in the same cycle, and SHALL otherwise reject it.
REQ-031 On accept, the block SHALL advance wr_buf_id by 1 modulo NP on the next edge.
REQ-032 On reject, the block SHALL hold wr_buf_id, assert wr_drop for one cycle, and increment drop_count, which saturates at all-ones.
REQ-033 On rd_release, the block SHALL release R=min(max(rd_count,1), occupancy) pages, advancing rd_buf_id by R modulo NP.
REQ-034 The block SHALL ignore rd_release when empty, with no error.
REQ-035 The block SHALL update occupancy each cycle as occupancy+accept-R; simultaneous accept and release in one cycle are both applied.
REQ-036 The block SHALL update hwm as max(hwm, next occupancy), registered.
REQ-037 The block SHALL register wr_addr one cycle after wr_ptr and wr_buf_id: mode 0 gives {wr_buf_id, wr_ptr[LOG2_BASE_WORDS-1:0]}, mode 1 gives {wr_buf_id[L-2:0], wr_ptr[LOG2_BASE_WORDS:0]}, mode 2 gives {wr_buf_id[L-3:0], wr_ptr[LOG2_BASE_WORDS+1:0]}.
REQ-038 The block SHALL maintain the invariant (wr_buf_id-rd_buf_id) mod NP == occupancy, checked by an assertion.
REQ-039 While clear is high, the block SHALL ignore wr_eoe and rd_release and SHALL NOT assert wr_drop.

Reset
REQ-040 While reset_n is low, the block SHALL asynchronously drive wr_buf_id, rd_buf_id, occupancy, hwm, drop_count, wr_addr and mode to 0, and wr_drop to 0.
REQ-041 After reset the block SHALL hold empty=1, full=0 and almost_full=0.
REQ-042 Reset deassertion SHALL be synchronous to clk, and the first accepted event SHALL be possible on the first edge after deassertion.
REQ-043 A clear SHALL produce the same register values as reset, except that mode takes page_size.
REQ-044 A reset or clear asserted mid-event SHALL discard all in-progress and completed pages.

Verification
REQ-045 A bench SHALL apply mode 0 with L=6 and 63 wr_eoe pulses and require occupancy=63, full=1 and wr_buf_id=63; a 64th pulse SHALL give wr_drop=1, drop_count=1 and wr_buf_id unchanged.
REQ-046 A bench SHALL, from the full state, pulse wr_eoe and rd_release with rd_count=1 in the same cycle and require accept, occupancy=63, wr_buf_id=0 (wrap) and rd_buf_id=1.
REQ-047 A bench SHALL apply mode 2 with 5 events, then rd_release with rd_count=8, and require occupancy=0, rd_buf_id=5 and buf_id bits [5:4]=0 throughout.
REQ-048 A bench SHALL apply mode 1 with wr_buf_id=3 and wr_ptr=0x155, and require wr_addr=(3<<10)|0x155 one cycle later.
REQ-049 A bench SHALL, with afull_thresh=10 in mode 0, bring occupancy to 12 and release 12, and require almost_full to rise at 10 and fall at 9, with hwm=12 held.
REQ-050 A bench SHALL pulse reset_n low mid-burst with occupancy=20 and drop_count=3 and require all counters to be 0 immediately, without waiting for a clock edge.
